// File: rtl/mult_share_pkg.sv
// Shared types and sizes for the two-requester multiplier sequencer.
package mult_share_pkg;

   typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

   localparam int N_REQ = 2;
   localparam int CNT_W = 16;

endpackage

// File: rtl/mult_share_ctrl_rr_arb2.sv
// Two-input round-robin grant; the last_grant history is held by the parent.
module rr_arb2
   import mult_share_pkg::*;
(
   input  logic [N_REQ-1:0] req_valid,
   input  logic             last_grant,
   output logic             grant,
   output logic             grant_vld
);

   always_comb begin
      grant_vld = |req_valid;
      grant     = 1'b0;
      // Under contention, the requester that did not win last time goes next.
      if (&req_valid) grant = ~last_grant;
      else if (req_valid[1]) grant = 1'b1;
   end

endmodule

// File: rtl/multiplier_cla.sv
// Lab combinational multiplier: unsigned, full-width product of two operands.
module multiplier_cla #(
   parameter int WA = 32,
   parameter int WB = 32
) (
   input  logic [WA-1:0]    multicand,
   input  logic [WB-1:0]    multiplier,
   output logic [WA+WB-1:0] product
);

   assign product = {{WB{1'b0}}, multicand} * {{WA{1'b0}}, multiplier};

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one multiplier_cla between two requesters with registered operands and product.
// state | meaning
// IDLE  | waiting for a request; req_ready driven for the granted requester
// CALC  | operand registers feed the multiplier; product captured at the edge
// RESP  | resp_valid high, product/resp_id held until resp_ready
module mult_share_ctrl
   import mult_share_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req_valid,
   output logic [N_REQ-1:0]   req_ready,
   input  logic [WIDTH-1:0]   req_a0,
   input  logic [WIDTH-1:0]   req_b0,
   input  logic [WIDTH-1:0]   req_a1,
   input  logic [WIDTH-1:0]   req_b1,
   output logic               resp_valid,
   input  logic               resp_ready,
   output logic               resp_id,
   output logic [2*WIDTH-1:0] product,
   output logic               busy,
   output logic [CNT_W-1:0]   op_count
);

   state_t             state, state_nxt;
   logic               last_grant;
   logic               grant;
   logic               grant_vld;
   logic               id_q;
   logic [WIDTH-1:0]   op_a;
   logic [WIDTH-1:0]   op_b;
   logic [2*WIDTH-1:0] mul_p;

   rr_arb2 u_arb (
      .req_valid  (req_valid),
      .last_grant (last_grant),
      .grant      (grant),
      .grant_vld  (grant_vld)
   );

   multiplier_cla #(WIDTH, WIDTH) u_mul (
      .multicand  (op_a),
      .multiplier (op_b),
      .product    (mul_p)
   );

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      case (state)
         IDLE: begin
            if (grant_vld) begin
               req_ready[grant] = 1'b1;
               state_nxt        = CALC;
            end
         end
         CALC:    state_nxt = RESP;
         RESP:    if (resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         op_a       <= '0;
         op_b       <= '0;
         id_q       <= 1'b0;
         product    <= '0;
         resp_id    <= 1'b0;
         op_count   <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && grant_vld) begin
            op_a       <= grant ? req_a1 : req_a0;
            op_b       <= grant ? req_b1 : req_b0;
            id_q       <= grant;
            last_grant <= grant;
         end
         if (state == CALC) begin
            product <= mul_p;
            resp_id <= id_q;
         end
         if (state == RESP && resp_ready) op_count <= op_count + 1'b1;
      end
   end

   assign resp_valid = (state == RESP);
   assign busy       = (state != IDLE);

endmodule
